// File: rtl/mem_miss_arbiter.sv
// ============================================================================
// Module   : mem_miss_arbiter
// Purpose  : Arbitrates D-cache write-throughs, D-miss fills and I-miss fills
//            onto the single port of the pipelined main memory. A fill issues
//            one read per cycle for every word of the block, streams the
//            returned words into the selected cache's data array, and then
//            pulses the tag/valid write. busy holds the pipeline stalled while
//            any operation is in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_miss, i_miss_addr        I-cache miss request (level) and fetch address
//   d_miss, d_miss_addr        D-cache load miss request (level) and address
//   d_wr_req/addr/data         store write-through request (held until wr_ack)
//   mem_addr/enable/wr/data_in memory request port
//   mem_data_out/data_valid    memory read return
//   fill_data/word_en/word_idx data-array write for the block being filled
//   fill_sel_d                 1 = fill targets D-cache, 0 = I-cache
//   fill_tag_we                one-cycle tag/valid write at end of fill
//   wr_ack                     store accepted by memory this cycle
//   busy                       operation in progress (pipeline stall)
// Optional build macro
//   ARB_PERF_CNT_EN : adds saturating fill counters i_fill_count/d_fill_count
// ============================================================================
`default_nettype none

module mem_miss_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_word_en,
  output logic [2:0]        fill_word_idx,
  output logic              fill_sel_d,
  output logic              fill_tag_we,
  output logic              wr_ack,
  output logic              busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       i_fill_count,
  output logic [15:0]       d_fill_count
`endif
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  // Byte-offset bits inside one block (words are DATA_W/8 bytes wide).
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK * (DATA_W / 8));
  localparam logic [ADDR_W-1:0] BLOCK_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  issue_cnt;   // index of the next read to issue
  logic [IDX_W-1:0]  rcv_cnt;     // index of the next word expected back
  logic              issued_all;  // separate flag: issue_cnt wraps to 0 after the last read

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= '0;
      issue_cnt   <= '0;
      rcv_cnt     <= '0;
      issued_all  <= 1'b0;
      mem_addr    <= '0;
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_data_in <= '0;
      fill_sel_d  <= 1'b0;
      fill_tag_we <= 1'b0;
      wr_ack      <= 1'b0;
    end else begin
      wr_ack      <= 1'b0;
      fill_tag_we <= 1'b0;
      case (state)
        IDLE: begin
          if (d_wr_req) begin
            state       <= WRITE;
            mem_enable  <= 1'b1;
            mem_wr      <= 1'b1;
            mem_addr    <= d_wr_addr;
            mem_data_in <= d_wr_data;
            wr_ack      <= 1'b1;
          end else if (d_miss || i_miss) begin
            // D side wins a simultaneous miss; the first read (word 0) goes
            // out in the very first FILL cycle.
            state      <= FILL;
            fill_sel_d <= d_miss;
            base       <= (d_miss ? d_miss_addr : i_miss_addr) & BLOCK_MASK;
            mem_addr   <= (d_miss ? d_miss_addr : i_miss_addr) & BLOCK_MASK;
            mem_enable <= 1'b1;
            mem_wr     <= 1'b0;
            issue_cnt  <= IDX_W'(1);
            issued_all <= 1'b0;
            rcv_cnt    <= '0;
          end
        end

        WRITE: begin
          state       <= IDLE;
          mem_enable  <= 1'b0;
          mem_wr      <= 1'b0;
          mem_data_in <= '0;
        end

        FILL: begin
          if (!issued_all) begin
            if (issue_cnt == '0) begin
              mem_enable <= 1'b0;
              issued_all <= 1'b1;
            end else begin
              mem_addr  <= base | (ADDR_W'(issue_cnt) << 1);
              issue_cnt <= issue_cnt + 1'b1;
            end
          end
          // Completion is driven purely by returned words, so gaps and late
          // data from memory simply stretch the FILL state.
          if (mem_data_valid) begin
            rcv_cnt <= rcv_cnt + 1'b1;
            if (rcv_cnt == LAST_IDX) begin
              state       <= DONE;
              fill_tag_we <= 1'b1;
              mem_enable  <= 1'b0;
            end
          end
        end

        DONE: begin
          state      <= IDLE;
          issue_cnt  <= '0;
          rcv_cnt    <= '0;
          issued_all <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // The word write must land in the same cycle the memory presents it.
  assign fill_data     = mem_data_out;
  assign fill_word_en  = (state == FILL) && mem_data_valid;
  assign fill_word_idx = 3'(rcv_cnt);
  assign busy          = (state != IDLE);

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_fill_count <= '0;
      d_fill_count <= '0;
    end else if (state == DONE) begin
      if (fill_sel_d) begin
        if (d_fill_count != 16'hFFFF) d_fill_count <= d_fill_count + 16'd1;
      end else begin
        if (i_fill_count != 16'hFFFF) i_fill_count <= i_fill_count + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
